// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive-side controller: controller
// state encoding and default character/oversampling constants that are
// also used by the deserialiser and transmitter.
package uart_rx_ctrl_pkg;

  localparam int UART_DATA_BITS_DEFAULT    = 8;
  localparam int UART_OVERSAMPLING_DEFAULT = 8;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'b00,
    S_ACTIVE  = 2'b01,
    S_TIMEOUT = 2'b10
  } rxc_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// dout whenever empty is low. Pointers carry one extra wrap bit so that
// full and empty are distinguished by the MSB alone.
module uart_sync_fifo
  import uart_rx_ctrl_pkg::*;
#(
  parameter int WIDTH = UART_DATA_BITS_DEFAULT,
  parameter int DEPTH = 8
) (
  input  logic                   sysclk_in,
  input  logic                   nrst_in,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             pop_acc_s;
  logic             push_acc_s;

  assign empty      = (wr_ptr_r == rd_ptr_r);
  assign full       = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  // A pop frees a slot in the same cycle, so a push while full is still
  // accepted when it coincides with a pop.
  assign pop_acc_s  = pop & ~empty;
  assign push_acc_s = push & (~full | pop_acc_s);
  assign level      = wr_ptr_r - rd_ptr_r;
  assign dout       = mem_r[rd_ptr_r[AW-1:0]];

  // Advance write/read pointers on accepted push/pop
  always_ff @(posedge sysclk_in) begin
    if (!nrst_in) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_acc_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

  // Storage array, cleared on reset so the head reads as zero afterwards
  always_ff @(posedge sysclk_in) begin
    if (!nrst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_acc_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller between the UART deserialiser and the consumer.
// Captures each completed character into a FWFT FIFO, exposes it as a
// valid/ready stream, and tracks overrun, character timeout and a
// fill-level interrupt.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DATA_BITS    = UART_DATA_BITS_DEFAULT,
  parameter int FIFO_DEPTH   = 8,
  parameter int OVERSAMPLING = UART_OVERSAMPLING_DEFAULT,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic                          sysclk_in,
  input  logic                          nrst_in,
  input  logic                          divpulse_in,
  input  logic                          rx_rdy_in,
  input  logic [DATA_BITS-1:0]          rx_data_in,
  output logic [DATA_BITS-1:0]          m_data_out,
  output logic                          m_valid_out,
  input  logic                          m_ready_in,
  input  logic [$clog2(FIFO_DEPTH):0]   thresh_in,
  input  logic                          ovr_clr_in,
  output logic [$clog2(FIFO_DEPTH):0]   level_out,
  output logic                          overrun_out,
  output logic                          timeout_out,
  output logic                          irq_out
);

  localparam int LW   = $clog2(FIFO_DEPTH) + 1;
  localparam int TMAX = TIMEOUT_BITS * OVERSAMPLING;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] TMAX_C = TW'(TMAX);

  rxc_state_e    state_r;
  logic          rdy_prev_r;
  logic [TW-1:0] tcnt_r;
  logic          overrun_r;
  logic          timeout_r;
  logic          irq_r;

  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          empty_s;
  logic [LW-1:0] level_s;
  logic          last_entry_s;
  logic          ovr_event_s;
  logic          thr_hit_s;

  // The deserialiser may hold rx_rdy_in for several cycles; only its
  // rising edge counts as a new character.
  assign push_s       = rx_rdy_in & ~rdy_prev_r;
  assign pop_s        = m_valid_out & m_ready_in;
  assign last_entry_s = (level_s == LW'(1));
  assign ovr_event_s  = push_s & full_s & ~pop_s;
  assign thr_hit_s    = (thresh_in != '0) && (level_s >= thresh_in);

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sysclk_in (sysclk_in),
    .nrst_in   (nrst_in),
    .push      (push_s),
    .pop       (pop_s),
    .din       (rx_data_in),
    .dout      (m_data_out),
    .full      (full_s),
    .empty     (empty_s),
    .level     (level_s)
  );

  assign m_valid_out = ~empty_s;
  assign level_out   = level_s;
  assign overrun_out = overrun_r;
  assign timeout_out = timeout_r;
  assign irq_out     = irq_r;

  // Remember last rx_rdy_in for rising-edge detection
  always_ff @(posedge sysclk_in) begin
    if (!nrst_in) begin
      rdy_prev_r <= 1'b0;
    end else begin
      rdy_prev_r <= rx_rdy_in;
    end
  end

  // Sticky overrun flag; a new drop wins over a simultaneous clear
  always_ff @(posedge sysclk_in) begin
    if (!nrst_in) begin
      overrun_r <= 1'b0;
    end else if (ovr_event_s) begin
      overrun_r <= 1'b1;
    end else if (ovr_clr_in) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  // Idle-time counter in oversampling ticks, saturating at the timeout
  always_ff @(posedge sysclk_in) begin
    if (!nrst_in) begin
      tcnt_r <= '0;
    end else if (push_s || pop_s || (state_r == S_EMPTY)) begin
      tcnt_r <= '0;
    end else if (divpulse_in && (tcnt_r != TMAX_C)) begin
      tcnt_r <= tcnt_r + TW'(1);
    end else begin
      tcnt_r <= tcnt_r;
    end
  end

  // Controller FSM with registered timeout flag
  always_ff @(posedge sysclk_in) begin
    if (!nrst_in) begin
      state_r   <= S_EMPTY;
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      case (state_r)
        S_EMPTY: begin
          if (push_s) begin
            state_r <= S_ACTIVE;
          end else begin
            state_r <= S_EMPTY;
          end
        end
        S_ACTIVE: begin
          if (push_s) begin
            state_r <= S_ACTIVE;
          end else if (pop_s && last_entry_s) begin
            state_r <= S_EMPTY;
          end else if (pop_s) begin
            state_r <= S_ACTIVE;
          end else if (tcnt_r == TMAX_C) begin
            state_r   <= S_TIMEOUT;
            timeout_r <= 1'b1;
          end else begin
            state_r <= S_ACTIVE;
          end
        end
        S_TIMEOUT: begin
          if (push_s) begin
            state_r <= S_ACTIVE;
          end else if (pop_s && last_entry_s) begin
            state_r <= S_EMPTY;
          end else if (pop_s) begin
            state_r <= S_ACTIVE;
          end else begin
            state_r   <= S_TIMEOUT;
            timeout_r <= 1'b1;
          end
        end
        default: begin
          state_r <= S_EMPTY;
        end
      endcase
    end
  end

  // Interrupt request: threshold, timeout or overrun, one cycle behind
  always_ff @(posedge sysclk_in) begin
    if (!nrst_in) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= thr_hit_s | timeout_r | overrun_r;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: scoreboard of expected characters
// plus a behavioural occupancy/flag model, checked by a negedge monitor.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;

  logic       sysclk_in = 1'b0;
  logic       nrst_in   = 1'b0;
  logic       divpulse_in = 1'b0;
  logic       rx_rdy_in = 1'b0;
  logic [7:0] rx_data_in = 8'h00;
  logic [7:0] m_data_out;
  logic       m_valid_out;
  logic       m_ready_in = 1'b0;
  logic [3:0] thresh_in = 4'd0;
  logic       ovr_clr_in = 1'b0;
  logic [3:0] level_out;
  logic       overrun_out;
  logic       timeout_out;
  logic       irq_out;

  uart_rx_ctrl dut (
    .sysclk_in   (sysclk_in),
    .nrst_in     (nrst_in),
    .divpulse_in (divpulse_in),
    .rx_rdy_in   (rx_rdy_in),
    .rx_data_in  (rx_data_in),
    .m_data_out  (m_data_out),
    .m_valid_out (m_valid_out),
    .m_ready_in  (m_ready_in),
    .thresh_in   (thresh_in),
    .ovr_clr_in  (ovr_clr_in),
    .level_out   (level_out),
    .overrun_out (overrun_out),
    .timeout_out (timeout_out),
    .irq_out     (irq_out)
  );

  always #5 sysclk_in = ~sysclk_in;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } dchk_t;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] sb_q[$];
  dchk_t      dq[$];

  // reference model state
  int   mlevel = 0;
  bit   m_ovr = 1'b0;
  bit   m_irq_next = 1'b0;
  bit   m_rdy_prev = 1'b0;
  int   thr_m = 0;
  int   exp_level_now = 0;
  bit   exp_ovr_now = 1'b0;
  bit   exp_irq_now = 1'b0;
  bit   mon_en = 1'b0;
  bit   chk_flags = 1'b1;
  logic [7:0]  last_pop = 8'h00;
  dchk_t       mon_d;
  logic [31:0] mon_act;
  logic [7:0]  mon_exp_b;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  function automatic void expect_out(input string n, input int s, input int e);
    dchk_t t;
    t.name = n;
    t.sel  = s;
    t.exp  = 32'(e);
    dq.push_back(t);
  endfunction

  // Monitor: directed expectations, scoreboard pops and per-cycle model checks
  always @(negedge sysclk_in) begin
    while (dq.size() > 0) begin
      mon_d = dq.pop_front();
      case (mon_d.sel)
        0: mon_act = 32'(m_valid_out);
        1: mon_act = 32'(m_data_out);
        2: mon_act = 32'(level_out);
        3: mon_act = 32'(overrun_out);
        4: mon_act = 32'(timeout_out);
        5: mon_act = 32'(irq_out);
        6: mon_act = 32'(sb_q.size());
        7: mon_act = 32'(last_pop);
        default: mon_act = 'x;
      endcase
      chk(mon_d.name, mon_act, mon_d.exp);
    end
    if (mon_en) begin
      if (m_valid_out && m_ready_in) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected actual=0x%0h required=none", m_data_out);
        end else begin
          mon_exp_b = sb_q.pop_front();
          chk("pop_data", 32'(m_data_out), 32'(mon_exp_b));
          last_pop = m_data_out;
        end
      end
      chk("level", 32'(level_out), 32'(exp_level_now));
      chk("valid", 32'(m_valid_out), 32'(exp_level_now != 0));
      chk("overrun", 32'(overrun_out), 32'(exp_ovr_now));
      if (chk_flags) begin
        chk("irq", 32'(irq_out), 32'(exp_irq_now));
        chk("timeout_idle", 32'(timeout_out), 32'(0));
      end
    end
  end

  // One clock of stimulus; the model advances by the same cycle's rules
  task automatic drive(input bit rdy, input logic [7:0] d, input bit rdyc, input bit dp, input bit clr);
    bit push_m;
    bit pop_m;
    bit ovr_evt;
    rx_rdy_in   = rdy;
    rx_data_in  = d;
    m_ready_in  = rdyc;
    divpulse_in = dp;
    ovr_clr_in  = clr;
    thresh_in   = 4'(thr_m);
    exp_level_now = mlevel;
    exp_ovr_now   = m_ovr;
    exp_irq_now   = m_irq_next;
    m_irq_next = ((thr_m != 0) && (mlevel >= thr_m)) || m_ovr;
    push_m  = rdy && !m_rdy_prev;
    pop_m   = rdyc && (mlevel > 0);
    ovr_evt = 1'b0;
    if (push_m) begin
      if ((mlevel < DEPTH) || pop_m) begin
        sb_q.push_back(d);
        mlevel++;
      end else begin
        ovr_evt = 1'b1;
      end
    end
    if (pop_m) mlevel--;
    if (ovr_evt) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    m_rdy_prev = rdy;
    @(posedge sysclk_in);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_byte(input logic [7:0] b, input bit rdyc);
    drive(1'b1, b, rdyc, 1'b0, 1'b0);
    drive(1'b0, 8'h00, rdyc, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    nrst_in = 1'b0;
    rx_rdy_in = 1'b0;
    m_ready_in = 1'b0;
    divpulse_in = 1'b0;
    ovr_clr_in = 1'b0;
    rx_data_in = 8'h00;
    @(posedge sysclk_in);
    #1;
    nrst_in = 1'b1;
    sb_q.delete();
    mlevel = 0;
    m_ovr = 1'b0;
    m_irq_next = 1'b0;
    m_rdy_prev = 1'b0;
    exp_level_now = 0;
    exp_ovr_now = 1'b0;
    exp_irq_now = 1'b0;
    expect_out("rst_valid", 0, 0);
    expect_out("rst_data", 1, 0);
    expect_out("rst_level", 2, 0);
    expect_out("rst_overrun", 3, 0);
    expect_out("rst_timeout", 4, 0);
    expect_out("rst_irq", 5, 0);
    mon_en = 1'b1;
  endtask

  initial begin
    int bias;
    bit nr;
    bias = 5;
    @(posedge sysclk_in);
    #1;
    do_reset();

    // single character from a 3-cycle-wide ready pulse
    drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    expect_out("first_valid", 0, 1);
    expect_out("first_data", 1, 8'hA5);
    expect_out("first_level", 2, 1);
    drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    expect_out("wide_pulse_level", 2, 1);
    idle(1);
    drain(1);
    idle(1);

    // overflow: nine characters into an eight-deep FIFO
    for (int b = 1; b <= 9; b++) push_byte(8'(b), 1'b0);
    expect_out("ovf_level", 2, 8);
    expect_out("ovf_overrun", 3, 1);
    expect_out("ovf_irq", 5, 1);
    drain(8);
    expect_out("ovf_drained", 2, 0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    expect_out("ovr_cleared", 3, 0);
    idle(2);

    // push and pop together while full
    for (int b = 0; b < 8; b++) push_byte(8'($urandom), 1'b0);
    drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    expect_out("full_pp_level", 2, 8);
    expect_out("full_pp_overrun", 3, 0);
    drain(8);
    expect_out("full_pp_last", 7, 8'h55);
    idle(2);

    // character timeout after 320 idle oversampling ticks
    chk_flags = 1'b0;
    push_byte(8'h77, 1'b0);
    for (int p = 0; p < 319; p++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      idle(3);
    end
    expect_out("to_before", 4, 0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle(3);
    expect_out("to_fired", 4, 1);
    expect_out("to_irq", 5, 1);
    drain(1);
    expect_out("to_cleared", 4, 0);
    expect_out("to_empty", 0, 0);
    idle(2);
    expect_out("to_irq_clear", 5, 0);
    chk_flags = 1'b1;
    idle(1);

    // threshold interrupt
    thr_m = 3;
    push_byte(8'h11, 1'b0);
    push_byte(8'h22, 1'b0);
    drive(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    expect_out("thr_level3", 2, 3);
    expect_out("thr_irq_lag", 5, 0);
    idle(1);
    expect_out("thr_irq_on", 5, 1);
    drain(1);
    expect_out("thr_irq_hold", 5, 1);
    idle(1);
    expect_out("thr_irq_off", 5, 0);
    drain(2);
    // threshold beyond depth never fires
    thr_m = 9;
    for (int b = 0; b < 8; b++) push_byte(8'($urandom), 1'b0);
    idle(2);
    expect_out("thr_over_depth", 5, 0);
    drain(8);
    thr_m = 0;
    idle(2);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      if ((c % 100) == 0) bias = int'($urandom_range(0, 9));
      if ((c % 50) == 0) thr_m = int'($urandom_range(0, 15));
      nr = ($urandom_range(0, 2) == 0) ? ~m_rdy_prev : m_rdy_prev;
      drive(nr, 8'($urandom), (int'($urandom_range(0, 9)) < bias), 1'b0,
            ($urandom_range(0, 15) == 0));
    end

    // reset with data stored
    thr_m = 0;
    drain(10);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int b = 0; b < 5; b++) push_byte(8'($urandom), 1'b0);
    expect_out("pre_rst_level", 2, 5);
    idle(1);
    do_reset();
    drive(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    expect_out("post_rst_data", 1, 8'h3C);
    expect_out("post_rst_level", 2, 1);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle(2);
    expect_out("sb_empty", 6, 0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side controller placed between `uart_rx` (serial deserialiser) and the bus or consumer logic.
- Captures each completed byte into a small synchronous FIFO and presents it through a valid/ready stream.
- Tracks overrun and character timeout (16550-style), and raises an interrupt when the fill level reaches a threshold.
- Sequences consumer service of the receive datapath; the deserialiser itself is untouched.

Parameters:
- DATA_BITS, 8: width of a received character.
- FIFO_DEPTH, 8: FIFO entries; must be a power of 2, minimum 2.
- OVERSAMPLING, 8: `divpulse_in` pulses per bit time; must match `uart_rx`.
- TIMEOUT_BITS, 40: idle bit-times (4 characters) before the timeout fires.

Ports:
- `sysclk_in`, in, 1: system clock; the only clock.
- `nrst_in`, in, 1: synchronous reset, active-low.
- `divpulse_in`, in, 1: single-cycle baud-generator oversampling tick.
- `rx_rdy_in`, in, 1: data-ready from `uart_rx`; may stay high for more than one cycle.
- `rx_data_in`, in, DATA_BITS: received character; valid while `rx_rdy_in` is high.
- `m_data_out`, out, DATA_BITS: head-of-FIFO character.
- `m_valid_out`, out, 1: FIFO not empty.
- `m_ready_in`, in, 1: consumer accepts `m_data_out`.
- `thresh_in`, in, $clog2(FIFO_DEPTH)+1: interrupt fill threshold; 0 disables the threshold term.
- `ovr_clr_in`, in, 1: clears the sticky overrun flag.
- `level_out`, out, $clog2(FIFO_DEPTH)+1: current FIFO occupancy, 0..FIFO_DEPTH.
- `overrun_out`, out, 1: sticky; a byte was dropped because the FIFO was full.
- `timeout_out`, out, 1: character-timeout pending.
- `irq_out`, out, 1: interrupt request.

Behaviour:
- All logic runs on posedge `sysclk_in`; the reset is synchronous and active-low.
- Reset values: `m_valid_out`=0, `m_data_out`=0, `level_out`=0, `overrun_out`=0, `timeout_out`=0, `irq_out`=0, FSM=S_EMPTY, pointers=0, timeout counter=0, rdy history register=0. Reset mid-operation discards FIFO contents.
- Push detect:
  - Push is the rising edge of `rx_rdy_in` (`rx_rdy_in` & ~previous value); exactly one push per frame.
  - `rx_data_in` is sampled in the push cycle.
- Pop: `m_valid_out` & `m_ready_in`.
- FIFO is first-word-fall-through:
  - A byte pushed in cycle N gives `m_valid_out`=1 and `m_data_out`=byte in cycle N+1.
  - `level_out` updates in the same cycle N+1.
- Full boundary:
  - Push while full and no pop: byte dropped, pointers unchanged, `overrun_out`<=1.
  - Push and pop while full: both accepted, level stays FIFO_DEPTH, no overrun.
- Empty boundary: pop cannot occur while empty; a push while empty gives level 1.
- Pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally; full/empty is decided by MSB comparison.
- `overrun_out`:
  - Held until `ovr_clr_in`.
  - If an overrun event and `ovr_clr_in` occur in the same cycle, the set wins.
- Timeout counter:
  - Width is $clog2(TIMEOUT_BITS*OVERSAMPLING)+1 bits.
  - Cleared on any push, any pop, or in S_EMPTY.
  - Otherwise increments on `divpulse_in` and saturates at TIMEOUT_BITS*OVERSAMPLING.
- FSM (controller state):
  - S_EMPTY: level 0. A push goes to S_ACTIVE.
  - S_ACTIVE: level > 0. Counter reaching TIMEOUT_BITS*OVERSAMPLING goes to S_TIMEOUT. A pop leaving level 0 with no push goes to S_EMPTY.
  - S_TIMEOUT: `timeout_out`=1 (registered, asserted the cycle after entry). A push or a non-emptying pop goes to S_ACTIVE; a pop to empty goes to S_EMPTY.
  - Same-cycle push+pop counts as activity and returns/stays in S_ACTIVE.
- `irq_out`, registered, is the OR of:
  - (`thresh_in`!=0 & `level_out`>=`thresh_in`);
  - `timeout_out`;
  - `overrun_out`.
  - It deasserts one cycle after the causing condition clears.
- `thresh_in` > FIFO_DEPTH means the threshold term never fires.

Decomposition:
- Shared header `uart_defs.vh`:
  - FSM state encodings (UART_RXC_EMPTY/ACTIVE/TIMEOUT, 2 bits);
  - a default DATA_BITS/OVERSAMPLING constant shared with `uart_rx` and `uart_tx`.
- Sub-module `uart_sync_fifo`:
  - parameterised WIDTH/DEPTH, FWFT, same clock/reset port names;
  - ports: push, pop, din, dout, full, empty, level.
  - It is reusable for the TX side.
- FSM, edge detect, timeout counter and flags stay in `uart_rx_ctrl`.

Test Plan:
- Reset, then push 0xA5 via a 3-cycle-wide `rx_rdy_in` pulse -> exactly one entry; the cycle after the edge, `m_valid_out`=1, `m_data_out`=0xA5, `level_out`=1.
- FIFO_DEPTH=8, push 9 bytes 0x01..0x09 with `m_ready_in`=0 -> `level_out`=8, `overrun_out`=1, `irq_out`=1; drain yields 0x01..0x08; `ovr_clr_in` clears `overrun_out`.
- FIFO full, push 0x55 and pop in the same cycle -> `overrun_out` stays 0, `level_out` stays 8, 0x55 is the last byte drained.
- Push one byte, hold `m_ready_in`=0, drive `divpulse_in` every 4 cycles -> `timeout_out` rises after 320 pulses; a pop clears it and the FSM returns to S_EMPTY.
- `thresh_in`=3, push 3 bytes -> `irq_out` rises one cycle after `level_out`=3; pop one -> `irq_out` falls one cycle later.
- Assert `nrst_in`=0 for one cycle with 5 bytes stored -> all outputs return to reset values and a following push is read back correctly.
